// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and lock supervisor: drives PLL RESETB, filters LOCK, retries failed
// locks and releases the downstream domain resets one after another.
module pll_lock_supervisor #(
  parameter int NUM_DOMAINS         = 2,
  parameter int CNT_W               = 24,
  parameter int RESET_HOLD_CYCLES   = 100,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int LOCK_STABLE_CYCLES  = 10000,
  parameter int RELEASE_SPACING     = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                   REFERENCECLK,
  input  logic                   RESET,
  input  logic                   LOCK,
  input  logic                   RESTART,
  output logic                   PLL_RESETB,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RESETN,
  output logic                   READY,
  output logic                   FAULT,
  output logic [7:0]             RETRY_COUNT,
  output logic [15:0]            LOCK_LOSS_COUNT
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPACING_LAST = CNT_W'(RELEASE_SPACING - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             lock_meta_reg;
  logic             lock_s_reg;
  logic [7:0]       retry_next;
  logic [15:0]      loss_next;

  // LOCK comes from the PLL analogue block with no timing relation to the reference clock
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= LOCK;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  always_comb begin
    retry_next = (RETRY_COUNT == 8'hFF) ? 8'hFF : RETRY_COUNT + 8'd1;
    loss_next  = (LOCK_LOSS_COUNT == 16'hFFFF) ? 16'hFFFF : LOCK_LOSS_COUNT + 16'd1;
  end

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state_reg       <= S_HOLD;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      PLL_RESETB      <= 1'b0;
      DOMAIN_RESETN   <= '0;
      READY           <= 1'b0;
      FAULT           <= 1'b0;
      RETRY_COUNT     <= 8'd0;
      LOCK_LOSS_COUNT <= 16'd0;
    end else if (RESTART) begin
      // Restart outranks any timeout or lock event in the same cycle
      state_reg     <= S_HOLD;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      PLL_RESETB    <= 1'b0;
      DOMAIN_RESETN <= '0;
      READY         <= 1'b0;
      FAULT         <= 1'b0;
      RETRY_COUNT   <= 8'd0;
    end else begin
      case (state_reg)
        S_HOLD: begin
          PLL_RESETB    <= 1'b0;
          DOMAIN_RESETN <= '0;
          if (cnt_reg == HOLD_LAST) begin
            state_reg  <= S_WAIT_LOCK;
            cnt_reg    <= '0;
            PLL_RESETB <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s_reg) begin
            state_reg <= S_STABLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            RETRY_COUNT <= retry_next;
            cnt_reg     <= '0;
            PLL_RESETB  <= 1'b0;
            if (retry_next >= RETRY_LIMIT) begin
              state_reg <= S_FAULT;
              FAULT     <= 1'b1;
            end else begin
              state_reg <= S_HOLD;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_STABLE: begin
          // A dropout here only restarts the wait; nothing has been released yet
          if (!lock_s_reg) begin
            state_reg <= S_WAIT_LOCK;
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg <= S_RELEASE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_RELEASE, S_RUN: begin
          if (!lock_s_reg) begin
            state_reg       <= S_HOLD;
            cnt_reg         <= '0;
            PLL_RESETB      <= 1'b0;
            DOMAIN_RESETN   <= '0;
            READY           <= 1'b0;
            LOCK_LOSS_COUNT <= loss_next;
          end else if (state_reg == S_RELEASE) begin
            if (cnt_reg == SPACING_LAST) begin
              DOMAIN_RESETN[idx_reg] <= 1'b1;
              cnt_reg                <= '0;
              if (idx_reg == IDX_LAST) begin
                state_reg   <= S_RUN;
                READY       <= 1'b1;
                RETRY_COUNT <= 8'd0;
              end else begin
                idx_reg <= idx_reg + 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        S_FAULT: begin
          PLL_RESETB    <= 1'b0;
          DOMAIN_RESETN <= '0;
          FAULT         <= 1'b1;
        end
        default: begin
          state_reg <= S_HOLD;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: output-change events are matched against a queue of
// expected (cycle, value) pairs pushed by each scenario task.
module tb_pll_lock_supervisor;

  localparam int HOLD    = 4;
  localparam int TIMEOUT = 50;
  localparam int STABLE  = 8;
  localparam int SPACING = 3;
  localparam int NDOM    = 2;
  localparam int MAXR    = 3;
  localparam int SYNC    = 3;  // 2 sync flops + FSM register

  // event vector = {PLL_RESETB, FAULT, READY, DOMAIN_RESETN[1:0]}
  localparam logic [4:0] V_ALL0 = 5'b00000;
  localparam logic [4:0] V_PLL  = 5'b10000;
  localparam logic [4:0] V_D0   = 5'b10001;
  localparam logic [4:0] V_RUN  = 5'b10111;
  localparam logic [4:0] V_FLT  = 5'b01000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            lock;
  logic            restart;
  logic            pll_resetb;
  logic [NDOM-1:0] domain_resetn;
  logic            ready;
  logic            fault;
  logic [7:0]      retry_count;
  logic [15:0]     lock_loss_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         c;
    logic [4:0] v;
  } ev_t;
  ev_t exp_q[$];

  logic [4:0] obs;
  logic [4:0] prev_obs;
  assign obs = {pll_resetb, fault, ready, domain_resetn};

  pll_lock_supervisor #(
    .NUM_DOMAINS(NDOM), .CNT_W(24), .RESET_HOLD_CYCLES(HOLD),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT), .LOCK_STABLE_CYCLES(STABLE),
    .RELEASE_SPACING(SPACING), .MAX_RETRIES(MAXR)
  ) dut (
    .REFERENCECLK(clk),
    .RESET(rst_n),
    .LOCK(lock),
    .RESTART(restart),
    .PLL_RESETB(pll_resetb),
    .DOMAIN_RESETN(domain_resetn),
    .READY(ready),
    .FAULT(fault),
    .RETRY_COUNT(retry_count),
    .LOCK_LOSS_COUNT(lock_loss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every output change pops the oldest expectation
  always @(negedge clk) begin
    ev_t e;
    if (rst_n === 1'b1 && obs !== prev_obs) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc %0d got %b want none", cyc, obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e.v || cyc !== e.c) begin
          errors++;
          $display("FAIL event got cyc %0d out %b want cyc %0d out %b", cyc, obs, e.c, e.v);
        end else begin
          $display("event cyc %0d out %b", cyc, obs);
        end
      end
    end
    prev_obs = obs;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input int c, input logic [4:0] v);
    ev_t e;
    e.c = c;
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lock = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL reset_pll got %b want 0", pll_resetb); end
    checks++; if (domain_resetn !== 2'b00) begin errors++; $display("FAIL reset_dom got %b want 00", domain_resetn); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL reset_retry got %0d want 0", retry_count); end
    checks++; if (lock_loss_count !== 16'd0) begin errors++; $display("FAIL reset_loss got %0d want 0", lock_loss_count); end
  endtask

  task automatic test_bringup();
    int t0;
    int l;
    rst_n = 1'b1;
    t0 = cyc;
    l  = t0 + 10;
    push(t0 + HOLD, V_PLL);
    push(l + SYNC + STABLE + SPACING, V_D0);
    push(l + SYNC + STABLE + 2 * SPACING, V_RUN);
    tick_to(l);
    lock = 1'b1;
    tick_to(t0 + 32);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bringup_ready got %b want 1", ready); end
    checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL bringup_retry got %0d want 0", retry_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bringup_pending got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_lock_loss();
    int t;
    int l;
    t = cyc;
    lock = 1'b0;
    l = t + SYNC + HOLD + 3;
    push(t + SYNC, V_ALL0);
    push(t + SYNC + HOLD, V_PLL);
    push(l + SYNC + STABLE + SPACING, V_D0);
    push(l + SYNC + STABLE + 2 * SPACING, V_RUN);
    tick_to(t + SYNC + 1);
    checks++; if (lock_loss_count !== 16'd1) begin errors++; $display("FAIL loss_count got %0d want 1", lock_loss_count); end
    tick_to(l);
    lock = 1'b1;
    tick_to(l + 22);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_reready got %b want 1", ready); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL loss_pending got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_glitch();
    int r;
    int w;
    r = cyc;
    w = r + 1 + HOLD;
    // Dropout seen by the FSM after 5 clean STABLE edges, then a fresh WAIT_LOCK edge
    push(r + 1, V_ALL0);
    push(w, V_PLL);
    push(w + 1 + 5 + 1 + 1 + STABLE + SPACING, V_D0);
    push(w + 1 + 5 + 1 + 1 + STABLE + 2 * SPACING, V_RUN);
    pulse_restart();
    tick_to(w + 1 + 5 + 1 - SYNC);
    lock = 1'b0;
    @(negedge clk);
    lock = 1'b1;
    tick_to(r + 32);
    checks++; if (lock_loss_count !== 16'd1) begin errors++; $display("FAIL glitch_loss got %0d want 1", lock_loss_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_pending got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_timeout();
    int r;
    int w;
    int t;
    r = cyc;
    w = r + 1 + HOLD;
    push(r + 1, V_ALL0);
    push(w, V_PLL);
    for (int k = 1; k <= MAXR; k++) begin
      t = w + TIMEOUT;
      push(t, (k == MAXR) ? V_FLT : V_ALL0);
      w = t + HOLD;
      if (k < MAXR) push(w, V_PLL);
    end
    lock = 1'b0;
    pulse_restart();
    tick_to(r + 1 + HOLD + TIMEOUT + 1);
    checks++; if (retry_count !== 8'd1) begin errors++; $display("FAIL timeout_retry1 got %0d want 1", retry_count); end
    tick_to(r + 170);
    lock = 1'b1;
    tick_to(r + 200);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL timeout_fault got %b want 1", fault); end
    checks++; if (retry_count !== 8'd3) begin errors++; $display("FAIL timeout_retry got %0d want 3", retry_count); end
    checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL timeout_pll got %b want 0", pll_resetb); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_pending got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_restart_from_fault();
    int r;
    r = cyc;
    push(r + 1, V_ALL0);
    push(r + 1 + HOLD, V_PLL);
    push(r + 1 + HOLD + 1 + STABLE + SPACING, V_D0);
    push(r + 1 + HOLD + 1 + STABLE + 2 * SPACING, V_RUN);
    pulse_restart();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL restart_fault got %b want 0", fault); end
    checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL restart_retry got %0d want 0", retry_count); end
    checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL restart_pll got %b want 0", pll_resetb); end
    tick_to(r + 25);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL restart_ready got %b want 1", ready); end
    checks++; if (lock_loss_count !== 16'd1) begin errors++; $display("FAIL restart_loss got %0d want 1", lock_loss_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_pending got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_async_reset();
    int r;
    int n;
    r = cyc;
    push(r + 1, V_ALL0);
    push(r + 1 + HOLD, V_PLL);
    push(r + 1 + HOLD + 1 + STABLE + SPACING, V_D0);
    pulse_restart();
    tick_to(r + 1 + HOLD + 1 + STABLE + SPACING);
    checks++; if (domain_resetn !== 2'b01) begin errors++; $display("FAIL areset_mid got %b want 01", domain_resetn); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs !== V_ALL0) begin errors++; $display("FAIL areset_out got %b want %b", obs, V_ALL0); end
    checks++; if (lock_loss_count !== 16'd0) begin errors++; $display("FAIL areset_loss got %0d want 0", lock_loss_count); end
    checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL areset_retry got %0d want 0", retry_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL areset_pending got %0d want 0", exp_q.size()); exp_q.delete(); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = cyc;
    // LOCK is already high, so lock_s is valid before WAIT_LOCK is entered
    push(n + HOLD, V_PLL);
    push(n + HOLD + 1 + STABLE + SPACING, V_D0);
    push(n + HOLD + 1 + STABLE + 2 * SPACING, V_RUN);
    tick_to(n + 25);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b want 1", ready); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL areset_pending2 got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_glitch();
    test_timeout();
    test_restart_from_fault();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
